// File: rtl/arp_reply_gen_if.sv
// AXI-Stream transmit bundle carrying one full ARP frame per beat.
// master drives data/valid/keep/last, slave returns ready.
interface arp_reply_gen_if #(
   parameter int DATA_WIDTH = 512
) ();
   logic [DATA_WIDTH-1:0]   tdata;
   logic [DATA_WIDTH/8-1:0] tkeep;
   logic                    tvalid;
   logic                    tlast;
   logic                    tready;

   modport master (output tdata, tkeep, tvalid, tlast, input tready);
   modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/arp_reply_gen.sv
// ARP reply builder: one parsed peer in, one single-beat 512-bit reply out, with a one-deep pending buffer.
// Optional macro ARP_REQ_EN adds a lowest-priority broadcast ARP request generator.
module arp_reply_gen #(
   parameter int C_AXIS_DATA_WIDTH = 512
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [47:0] local_mac,
   input  logic [31:0] local_ip,
   input  logic [47:0] arp_src_mac,
   input  logic [31:0] arp_src_ip,
   input  logic        arp_rx_valid,
`ifdef ARP_REQ_EN
   input  logic        arp_req,
   input  logic [31:0] arp_req_ip,
`endif
   arp_reply_gen_if.master tx_m_axis,
   output logic [47:0] peer_mac,
   output logic [31:0] peer_ip,
   output logic        peer_valid,
   output logic [15:0] arp_drop_cnt
);

   localparam int KEEP_W = C_AXIS_DATA_WIDTH / 8;

   // A frame is exactly one beat, so any other width cannot hold it.
   if (C_AXIS_DATA_WIDTH != 512) begin : g_bad_width
      $error("arp_reply_gen supports only C_AXIS_DATA_WIDTH = 512");
   end

   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

   state_t                         state_q, state_d;
   logic [C_AXIS_DATA_WIDTH-1:0]   tdata_q, tdata_d;
   logic                           pend_q, pend_d;
   logic [47:0]                    pend_mac_q, pend_mac_d;
   logic [31:0]                    pend_ip_q, pend_ip_d;
   logic [47:0]                    peer_mac_q, peer_mac_d;
   logic [31:0]                    peer_ip_q, peer_ip_d;
   logic                           peer_valid_q, peer_valid_d;
   logic [15:0]                    drop_cnt_q, drop_cnt_d;

   logic        load_pend, load_rx, load_req, load_any, buf_wr;
   logic [47:0] reply_mac;
   logic [31:0] reply_ip;

   function automatic logic [511:0] build_frame(input logic [47:0] dst,
                                                input logic [15:0] oper,
                                                input logic [47:0] tha,
                                                input logic [31:0] tpa,
                                                input logic [47:0] my_mac,
                                                input logic [31:0] my_ip);
      return {dst, my_mac, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04,
              oper, my_mac, my_ip, tha, tpa, 176'd0};
   endfunction

`ifdef ARP_REQ_EN
   logic        req_q, req_d;
   logic [31:0] req_ip_q, req_ip_d;
`endif

   assign load_pend = (state_q == IDLE) && pend_q;
   assign load_rx   = (state_q == IDLE) && !pend_q && arp_rx_valid;
`ifdef ARP_REQ_EN
   assign load_req  = (state_q == IDLE) && !pend_q && !arp_rx_valid && req_q;
`else
   assign load_req  = 1'b0;
`endif
   assign load_any  = load_pend || load_rx || load_req;
   assign buf_wr    = arp_rx_valid && ((state_q == SEND) || load_pend);
   assign reply_mac = load_pend ? pend_mac_q : arp_src_mac;
   assign reply_ip  = load_pend ? pend_ip_q  : arp_src_ip;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (load_any) state_d = SEND;
         SEND:    if (tx_m_axis.tready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      tx_m_axis.tvalid = (state_q == SEND);
      tx_m_axis.tlast  = (state_q == SEND);
      tx_m_axis.tkeep  = {KEEP_W{state_q == SEND}};
      tx_m_axis.tdata  = tdata_q;
   end

   // Frame capture, pending buffer, peer record and drop counter.
   always_comb begin
      tdata_d      = tdata_q;
      pend_d       = pend_q;
      pend_mac_d   = pend_mac_q;
      pend_ip_d    = pend_ip_q;
      peer_mac_d   = peer_mac_q;
      peer_ip_d    = peer_ip_q;
      peer_valid_d = peer_valid_q;
      drop_cnt_d   = drop_cnt_q;

      if (load_pend || load_rx) begin
         tdata_d      = build_frame(reply_mac, 16'h0002, reply_mac, reply_ip,
                                    local_mac, local_ip);
         peer_mac_d   = reply_mac;
         peer_ip_d    = reply_ip;
         peer_valid_d = 1'b1;
      end
`ifdef ARP_REQ_EN
      else if (load_req) begin
         tdata_d = build_frame(48'hFFFF_FFFF_FFFF, 16'h0001, 48'd0, req_ip_q,
                               local_mac, local_ip);
      end
`endif

      if (load_pend) pend_d = 1'b0;
      if (buf_wr) begin
         pend_d     = 1'b1;
         pend_mac_d = arp_src_mac;
         pend_ip_d  = arp_src_ip;
         if (pend_q && !load_pend && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         tdata_q      <= '0;
         pend_q       <= 1'b0;
         pend_mac_q   <= '0;
         pend_ip_q    <= '0;
         peer_mac_q   <= '0;
         peer_ip_q    <= '0;
         peer_valid_q <= 1'b0;
         drop_cnt_q   <= '0;
      end else begin
         tdata_q      <= tdata_d;
         pend_q       <= pend_d;
         pend_mac_q   <= pend_mac_d;
         pend_ip_q    <= pend_ip_d;
         peer_mac_q   <= peer_mac_d;
         peer_ip_q    <= peer_ip_d;
         peer_valid_q <= peer_valid_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

`ifdef ARP_REQ_EN
   // A new pulse re-arms the request even if the old one is being loaded now.
   always_comb begin
      req_d    = req_q;
      req_ip_d = req_ip_q;
      if (load_req) req_d = 1'b0;
      if (arp_req) begin
         req_d    = 1'b1;
         req_ip_d = arp_req_ip;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         req_q    <= 1'b0;
         req_ip_q <= '0;
      end else begin
         req_q    <= req_d;
         req_ip_q <= req_ip_d;
      end
   end
`endif

   assign peer_mac     = peer_mac_q;
   assign peer_ip      = peer_ip_q;
   assign peer_valid   = peer_valid_q;
   assign arp_drop_cnt = drop_cnt_q;

endmodule
